// File: rtl/psum_accum_buffer_if.sv
// Result handshake between the partial-sum accumulator and the writeback/pooling stage.
interface psum_accum_buffer_if #(
  parameter int OUT_W = 24
);
  logic [OUT_W-1:0] Psum_out;
  logic             Psum_valid;
  logic             Psum_ready;

  modport master (output Psum_out, output Psum_valid, input Psum_ready);
  modport slave  (input Psum_out, input Psum_valid, output Psum_ready);
endinterface

// File: rtl/psum_accum_buffer.sv
// Accumulates ACC_NUM strobed PE partial sums per pixel and queues results in a FWFT FIFO.
// Define PSUM_RELU_EN to ReLU-clamp completed pixels at FIFO write.
module psum_accum_buffer #(
  parameter int IN_W       = 20,
  parameter int ACC_NUM    = 4,
  parameter int OUT_W      = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                PE_clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clr,
  input  logic [IN_W-1:0]     Conv_result,
  input  logic                PE_out_clk,
  psum_accum_buffer_if.master psum,
  output logic [3:0]          Group_cnt,
  output logic                Fifo_full,
  output logic                Ovf_err
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0]    LAST    = 4'(ACC_NUM - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic             pe_clk_d;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic             strobe;
  logic             push;
  logic             pop;
  logic             do_write;
  logic [OUT_W-1:0] x_ext;
  logic [OUT_W-1:0] sum;
  logic [OUT_W-1:0] wr_data;

  assign strobe   = PE_out_clk & ~pe_clk_d & en;
  assign x_ext    = {{(OUT_W-IN_W){Conv_result[IN_W-1]}}, Conv_result};
  assign sum      = acc + x_ext;
  assign push     = strobe & (Group_cnt == LAST) & ~clr;
  assign pop      = psum.Psum_valid & psum.Psum_ready & ~clr;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_write = push & (~Fifo_full | pop);

  always_comb begin
    wr_data = sum;
`ifdef PSUM_RELU_EN
    if (sum[OUT_W-1]) wr_data = '0;
`endif
  end

  assign psum.Psum_valid = (count != '0);
  assign psum.Psum_out   = psum.Psum_valid ? mem[rd_ptr] : '0;
  assign Fifo_full       = (count == DEPTH_C);

  always_ff @(posedge PE_clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_clk_d  <= 1'b0;
      acc       <= '0;
      Group_cnt <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      Ovf_err   <= 1'b0;
    end else begin
      pe_clk_d <= PE_out_clk;
      if (clr) begin
        acc       <= '0;
        Group_cnt <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        Ovf_err   <= 1'b0;
      end else begin
        if (strobe) begin
          if (Group_cnt == LAST) begin
            acc       <= '0;
            Group_cnt <= '0;
          end else begin
            acc       <= sum;
            Group_cnt <= Group_cnt + 4'd1;
          end
        end
        if (push && !do_write) Ovf_err <= 1'b1;
        if (do_write) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(do_write) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: the read side is gated by the occupancy count.
  always_ff @(posedge PE_clk) begin
    if (do_write) mem[wr_ptr] <= wr_data;
  end
endmodule
